snake_grid_renderer: RTL
========================

# snake_grid_renderer

Renders the full snake (all segments, not only the head) onto the VGA pixel stream as coloured boxes on a parametrised tile grid, overlaying the background colour from the palette path. Once per frame, on `screenEnd`, it snapshots the segment coordinate arrays into a tile-occupancy bitmap using a sequential loader, then double-buffers that bitmap for display. It sits between `VGATimingGenerator`/palette RAM and the `VGA_R/G/B` output assignment.

## Interface
- `GRID_W`, 8: tile columns
- `GRID_H`, 8: tile rows
- `TILE`, 48: tile pitch in pixels
- `BOX`, 40: drawn box edge in pixels, `BOX <= TILE`
- `ORIGIN_X` / `ORIGIN_Y`, 48 / 48: pixel position of tile (0,0)
- `MAX_SEG`, 100: segment slots in the input arrays
- `COORD_W`, 32: bits per segment coordinate
- `HEAD_COLOR` / `BODY_COLOR`, 12'h0F0 / 12'h080: box colours
- `clk`  in  1  system clock; one clock only
- `reset`  in  1  asynchronous, active-high
- `x`, `y`  in  10 each  pixel coordinate from the timing generator
- `active`  in  1  visible-area flag
- `screenEnd`  in  1  one-cycle frame-boundary pulse
- `x_values`, `y_values`  in  MAX_SEG*COORD_W each  segment i at bits [i*COORD_W +: COORD_W]; segment 0 is the head
- `seg_len`  in  $clog2(MAX_SEG+1)  number of valid segments
- `bg_color`  in  12  palette colour for the current pixel
- `color_out`  out  12  final pixel colour
- `busy`  out  1  loader running
- `collide`  out  1  duplicate tile detected in the last completed load
- `oob`  out  1  out-of-grid segment seen in the last completed load

## Operation
- FSM states: IDLE, CLEAR, LOAD, SWAP.
- IDLE: on `screenEnd`, latch `min(seg_len, MAX_SEG)` into `n`, then go to CLEAR.
- CLEAR: zero the shadow bitmap (GRID_W*GRID_H bits) and the shadow head-tile register in one cycle, set `i = 0`, then go to LOAD. If `n == 0`, go to SWAP instead.
- LOAD: process one segment per cycle.
  - If `x_values[i] >= GRID_W` or `y_values[i] >= GRID_H`, set shadow oob and skip the segment.
  - Otherwise, if the shadow bit is already set, set shadow collide; then set the bit.
  - When `i == 0`, record the head tile.
  - When `i == n-1`, go to SWAP.
- SWAP: copy the shadow bitmap, head tile, collide and oob into the display copies in one cycle, then return to IDLE.
- `busy` is high in CLEAR, LOAD and SWAP.
- A `screenEnd` arriving while `busy` is ignored. The display keeps the previous bitmap.
- Pixel path: a pixel is inside a box when `x - ORIGIN_X - col*TILE < BOX` and `y - ORIGIN_Y - row*TILE < BOX`.
  - The column index is the count of k in 1..GRID_W-1 with `x >= ORIGIN_X + k*TILE`. The row index is computed the same way from `y`. No dividers.
  - Pixels outside the `[ORIGIN, ORIGIN + GRID*TILE)` window are never in a box.
- Colour selection:
  - Inside a box on an occupied tile: the head tile gets `HEAD_COLOR`, other tiles get `BODY_COLOR`.
  - Otherwise: `bg_color`.
  - When delayed `active` is 0: `color_out = 0`.
- Arithmetic is unsigned. Coordinates are compared at COORD_W bits before truncation, so no wrap-around aliasing.

## Timing
- Pixel path latency is 2 `clk` cycles: stage 1 computes tile and in-box, stage 2 does bitmap lookup and colour mux. `active` and `bg_color` are delayed to match.
- Loader takes `n + 2` cycles from `screenEnd` (0 segments: 2 cycles). With MAX_SEG=100 it completes well inside vertical blank.
- Display bitmap changes only in SWAP, so there is no mid-frame tearing.
- Reset (asynchronous, any state): FSM goes to IDLE and both bitmaps clear. `color_out = 0`, `busy = 0`, `collide = 0`, `oob = 0`, and both pipeline stages clear.

## Configuration
- `SNAKE_RENDER_COLLIDE_EN` defined: duplicate-tile detection logic is present and `collide` behaves as above.
- Not defined: `collide` is tied to 0 and the comparison logic is removed. Rendering is unchanged.

## Structure
- Package `snake_render_pkg` holds:
  - the FSM state enum
  - `COLOR_W = 12`
  - default `HEAD_COLOR` / `BODY_COLOR`
- Sub-module `snake_tile_locator` implements pixel-to-tile and in-box logic (stage 1), parametrised on GRID, TILE, BOX and ORIGIN. One instance handles x and one handles y.

## Test plan
- **Single segment.** `seg_len=1`, head (0,0), pulse `screenEnd`. Next frame: pixel (48,48) gives `HEAD_COLOR` 2 cycles later; (87,48) gives `HEAD_COLOR`; (88,48) gives `bg_color`.
- **Body segment.** `seg_len=3`, (2,2),(2,3),(2,4). Pixel (144,240) gives `BODY_COLOR`; `busy` is high for exactly 5 cycles.
- **Duplicate tile.** `seg_len=2`, both segments (1,1). `collide=1` after SWAP; with the macro undefined, `collide` stays 0.
- **Out-of-grid segment.** `seg_len=1`, segment at x=8. `oob=1`, and no pixel is coloured.
- **Frame boundary while busy.** A second `screenEnd` during LOAD is ignored; the bitmap reflects only the first load.
- **Reset mid-operation.** Assert `reset` mid-LOAD. `busy` and `color_out` go to 0 immediately (asynchronously), and the display bitmap is empty after release.

Source files
------------

// File: rtl/snake_render_pkg.sv
// Shared types and constants for the snake grid renderer.
package snake_render_pkg;

    localparam int unsigned COLOR_W = 12;

    localparam logic [COLOR_W-1:0] DEF_HEAD_COLOR = 12'h0F0;
    localparam logic [COLOR_W-1:0] DEF_BODY_COLOR = 12'h080;

    // Loader state machine
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        LOAD  = 2'd2,
        SWAP  = 2'd3
    } render_state_e;

endpackage : snake_render_pkg

// File: rtl/snake_tile_locator.sv
// Pixel-to-tile mapping for one axis: tile index and in-box flag, registered.
// Uses a threshold count instead of a divider.
module snake_tile_locator #(
    parameter int unsigned GRID   = 8,
    parameter int unsigned TILE   = 48,
    parameter int unsigned BOX    = 40,
    parameter int unsigned ORIGIN = 48
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [9:0]                                coord_i,
    output logic [((GRID > 1) ? $clog2(GRID) : 1)-1:0] tile_o,
    output logic                                      in_box_o
);

    localparam int unsigned IW = (GRID > 1) ? $clog2(GRID) : 1;

    logic [31:0]   c;
    logic [31:0]   base;
    logic [31:0]   off;
    logic [IW-1:0] cnt;
    logic          in_win;
    logic          in_box;

    assign c = 32'(coord_i);

    // Count tile thresholds passed and remember the start of the current tile
    always_comb begin
        cnt  = '0;
        base = ORIGIN;
        for (int unsigned k = 1; k < GRID; k++) begin
            if (c >= ORIGIN + k * TILE) begin
                cnt  = cnt + IW'(1);
                base = ORIGIN + k * TILE;
            end
        end
        in_win = (c >= ORIGIN) && (c < ORIGIN + GRID * TILE);
        off    = c - base;
        in_box = in_win && (off < BOX);
    end

    // Stage-1 register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tile_o   <= '0;
            in_box_o <= 1'b0;
        end else begin
            tile_o   <= cnt;
            in_box_o <= in_box;
        end
    end

endmodule : snake_tile_locator

// File: rtl/snake_grid_renderer.sv
// Draws every snake segment as a box on a tile grid over the palette colour.
// A per-frame loader snapshots segment coordinates into a shadow bitmap,
// then swaps it into the display copy so a frame never shows a partial load.
// Optional feature macro: SNAKE_RENDER_COLLIDE_EN (duplicate-tile detection).
module snake_grid_renderer
    import snake_render_pkg::*;
#(
    parameter int unsigned        GRID_W     = 8,
    parameter int unsigned        GRID_H     = 8,
    parameter int unsigned        TILE       = 48,
    parameter int unsigned        BOX        = 40,
    parameter int unsigned        ORIGIN_X   = 48,
    parameter int unsigned        ORIGIN_Y   = 48,
    parameter int unsigned        MAX_SEG    = 100,
    parameter int unsigned        COORD_W    = 32,
    parameter logic [COLOR_W-1:0] HEAD_COLOR = DEF_HEAD_COLOR,
    parameter logic [COLOR_W-1:0] BODY_COLOR = DEF_BODY_COLOR
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [9:0]                     x,
    input  logic [9:0]                     y,
    input  logic                           active,
    input  logic                           screenEnd,
    input  logic [MAX_SEG*COORD_W-1:0]     x_values,
    input  logic [MAX_SEG*COORD_W-1:0]     y_values,
    input  logic [$clog2(MAX_SEG+1)-1:0]   seg_len,
    input  logic [COLOR_W-1:0]             bg_color,
    output logic [COLOR_W-1:0]             color_out,
    output logic                           busy,
    output logic                           collide,
    output logic                           oob
);

    localparam int unsigned IDX_W = $clog2(MAX_SEG + 1);
    localparam int unsigned COL_W = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int unsigned ROW_W = (GRID_H > 1) ? $clog2(GRID_H) : 1;
    localparam int unsigned NBITS = GRID_W * GRID_H;
    localparam int unsigned BIT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    render_state_e      state_q;
    logic [IDX_W-1:0]   n_q;
    logic [IDX_W-1:0]   i_q;
    logic               busy_q;

    logic [NBITS-1:0]   sh_map_q;
    logic [COL_W-1:0]   sh_hcol_q;
    logic [ROW_W-1:0]   sh_hrow_q;
    logic               sh_hvld_q;
    logic               sh_oob_q;

    logic [NBITS-1:0]   disp_map_q;
    logic [COL_W-1:0]   disp_hcol_q;
    logic [ROW_W-1:0]   disp_hrow_q;
    logic               disp_hvld_q;
    logic               disp_oob_q;

`ifdef SNAKE_RENDER_COLLIDE_EN
    logic               sh_coll_q;
    logic               disp_coll_q;
`endif

    // Segment currently addressed by the loader
    logic [COORD_W-1:0] seg_x;
    logic [COORD_W-1:0] seg_y;
    logic               seg_oob;
    logic [COL_W-1:0]   seg_col;
    logic [ROW_W-1:0]   seg_row;
    logic [BIT_W-1:0]   seg_bit;

    assign seg_x   = x_values[32'(i_q) * COORD_W +: COORD_W];
    assign seg_y   = y_values[32'(i_q) * COORD_W +: COORD_W];
    assign seg_oob = (seg_x >= COORD_W'(GRID_W)) || (seg_y >= COORD_W'(GRID_H));
    assign seg_col = COL_W'(seg_x);
    assign seg_row = ROW_W'(seg_y);
    assign seg_bit = BIT_W'(seg_row) * BIT_W'(GRID_W) + BIT_W'(seg_col);

    // Loader FSM: clear shadow, walk segments, swap into display copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            i_q         <= '0;
            busy_q      <= 1'b0;
            sh_map_q    <= '0;
            sh_hcol_q   <= '0;
            sh_hrow_q   <= '0;
            sh_hvld_q   <= 1'b0;
            sh_oob_q    <= 1'b0;
            disp_map_q  <= '0;
            disp_hcol_q <= '0;
            disp_hrow_q <= '0;
            disp_hvld_q <= 1'b0;
            disp_oob_q  <= 1'b0;
`ifdef SNAKE_RENDER_COLLIDE_EN
            sh_coll_q   <= 1'b0;
            disp_coll_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (screenEnd) begin
                        n_q     <= (seg_len > IDX_W'(MAX_SEG)) ? IDX_W'(MAX_SEG) : seg_len;
                        state_q <= CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    sh_map_q  <= '0;
                    sh_hcol_q <= '0;
                    sh_hrow_q <= '0;
                    sh_hvld_q <= 1'b0;
                    sh_oob_q  <= 1'b0;
`ifdef SNAKE_RENDER_COLLIDE_EN
                    sh_coll_q <= 1'b0;
`endif
                    i_q       <= '0;
                    state_q   <= (n_q == '0) ? SWAP : LOAD;
                end
                LOAD: begin
                    if (seg_oob) begin
                        sh_oob_q <= 1'b1;
                    end else begin
`ifdef SNAKE_RENDER_COLLIDE_EN
                        if (sh_map_q[seg_bit]) begin
                            sh_coll_q <= 1'b1;
                        end
`endif
                        sh_map_q[seg_bit] <= 1'b1;
                        if (i_q == '0) begin
                            sh_hcol_q <= seg_col;
                            sh_hrow_q <= seg_row;
                            sh_hvld_q <= 1'b1;
                        end
                    end
                    if (i_q == n_q - IDX_W'(1)) begin
                        state_q <= SWAP;
                    end else begin
                        i_q <= i_q + IDX_W'(1);
                    end
                end
                SWAP: begin
                    disp_map_q  <= sh_map_q;
                    disp_hcol_q <= sh_hcol_q;
                    disp_hrow_q <= sh_hrow_q;
                    disp_hvld_q <= sh_hvld_q;
                    disp_oob_q  <= sh_oob_q;
`ifdef SNAKE_RENDER_COLLIDE_EN
                    disp_coll_q <= sh_coll_q;
`endif
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign oob  = disp_oob_q;
`ifdef SNAKE_RENDER_COLLIDE_EN
    assign collide = disp_coll_q;
`else
    assign collide = 1'b0;
`endif

    // Stage 1: tile index and in-box per axis
    logic [COL_W-1:0]   col_s1;
    logic [ROW_W-1:0]   row_s1;
    logic               inx_s1;
    logic               iny_s1;
    logic               act_s1_q;
    logic [COLOR_W-1:0] bg_s1_q;

    snake_tile_locator #(
        .GRID   (GRID_W),
        .TILE   (TILE),
        .BOX    (BOX),
        .ORIGIN (ORIGIN_X)
    ) u_loc_x (
        .clk      (clk),
        .reset    (reset),
        .coord_i  (x),
        .tile_o   (col_s1),
        .in_box_o (inx_s1)
    );

    snake_tile_locator #(
        .GRID   (GRID_H),
        .TILE   (TILE),
        .BOX    (BOX),
        .ORIGIN (ORIGIN_Y)
    ) u_loc_y (
        .clk      (clk),
        .reset    (reset),
        .coord_i  (y),
        .tile_o   (row_s1),
        .in_box_o (iny_s1)
    );

    // Stage 1: delay active and background to match the locators
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_s1_q <= 1'b0;
            bg_s1_q  <= '0;
        end else begin
            act_s1_q <= active;
            bg_s1_q  <= bg_color;
        end
    end

    logic [BIT_W-1:0] pix_bit;
    logic             pix_occ;
    logic             pix_head;

    assign pix_bit  = BIT_W'(row_s1) * BIT_W'(GRID_W) + BIT_W'(col_s1);
    assign pix_occ  = inx_s1 && iny_s1 && disp_map_q[pix_bit];
    assign pix_head = disp_hvld_q && (col_s1 == disp_hcol_q) && (row_s1 == disp_hrow_q);

    // Stage 2: bitmap lookup and colour mux
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            color_out <= '0;
        end else if (!act_s1_q) begin
            color_out <= '0;
        end else if (pix_occ) begin
            color_out <= pix_head ? HEAD_COLOR : BODY_COLOR;
        end else begin
            color_out <= bg_s1_q;
        end
    end

endmodule : snake_grid_renderer
